tree_ensemble_sched: RTL and testbench

- Sequencer for a shared single-output decision-tree classifier (51-bit feature vector in, 1-bit class vote out).
- Accepts one feature vector per valid/ready handshake and holds it on the shared tree input.
- Steps a tree-select index through NUM_TREES trees, one per cycle, and accumulates the 1-bit votes.
- Emits a majority class decision and vote count on an output valid/ready handshake. Sits between the feature front-end and the result sink.

---
 rtl/tree_ens_pkg.sv | 24 ++
 rtl/tree_vote_acc.sv | 52 +++++
 rtl/tree_ensemble_sched.sv | 109 ++++++++++
 tb/tb_tree_ensemble_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_ens_pkg.sv
// Shared types and width helpers for the tree-ensemble sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tree_ens_pkg;

    localparam int FEAT_W_DEF = 51;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    // Tree-select index width; a single tree still needs one select bit.
    function automatic int sel_width(input int num_trees);
        return (num_trees > 1) ? $clog2(num_trees) : 1;
    endfunction

    // Vote count width: must hold 0..num_trees inclusive.
    function automatic int cnt_width(input int num_trees);
        return $clog2(num_trees + 1);
    endfunction

endpackage

// File: rtl/tree_vote_acc.sv
// Vote counter, threshold compare and stop decision (TREE_EARLY_EXIT_EN enables early stop).
// Latency: count/decided/vote_class are combinational on hit; the running total registers on en.
// Backpressure: none; the caller gates en.
module tree_vote_acc
    import tree_ens_pkg::*;
#(
    parameter int NUM_TREES   = 8,
    parameter int VOTE_THRESH = 5,
    parameter int CNT_W       = cnt_width(NUM_TREES),
    parameter int SEL_W       = sel_width(NUM_TREES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             hit,
    input  logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] count,
    output logic             decided,
    output logic             vote_class
);

    logic [CNT_W-1:0] count_q;
    logic [31:0]      total;
    logic [31:0]      remaining;
    logic             last_tree;

    // count already includes the vote of the tree currently selected.
    assign count     = count_q + CNT_W'(hit);
    assign total     = 32'(count);
    assign remaining = 32'(NUM_TREES - 1) - 32'(sel);
    assign last_tree = (sel == SEL_W'(NUM_TREES - 1));
    assign vote_class = (total >= 32'(VOTE_THRESH));

`ifdef TREE_EARLY_EXIT_EN
    // Stop once the remaining trees can no longer change the outcome.
    assign decided = last_tree || vote_class || ((total + remaining) < 32'(VOTE_THRESH));
`else
    assign decided = last_tree;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count;
        end
    end

endmodule

// File: rtl/tree_ensemble_sched.sv
// Sequences one feature vector through NUM_TREES shared trees and reports a majority vote (TREE_EARLY_EXIT_EN: early stop).
// Latency: accept in cycle T, trees evaluated in T+1..T+NUM_TREES, out_valid from T+NUM_TREES+1.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module tree_ensemble_sched
    import tree_ens_pkg::*;
#(
    parameter int FEAT_W      = FEAT_W_DEF,
    parameter int NUM_TREES   = 8,
    parameter int VOTE_THRESH = 5,
    localparam int SEL_W      = sel_width(NUM_TREES),
    localparam int CNT_W      = cnt_width(NUM_TREES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FEAT_W-1:0] in_feat,
    output logic [FEAT_W-1:0] tree_feat,
    output logic [SEL_W-1:0]  tree_sel,
    input  logic              tree_hit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_class,
    output logic [CNT_W-1:0]  out_votes
);

    sched_state_t     state, state_nxt;
    logic             accept;
    logic             eval_en;
    logic [CNT_W-1:0] acc_count;
    logic             acc_decided;
    logic             acc_class;

    tree_vote_acc #(
        .NUM_TREES  (NUM_TREES),
        .VOTE_THRESH(VOTE_THRESH),
        .CNT_W      (CNT_W),
        .SEL_W      (SEL_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .en        (eval_en),
        .hit       (tree_hit),
        .sel       (tree_sel),
        .count     (acc_count),
        .decided   (acc_decided),
        .vote_class(acc_class)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        eval_en   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                eval_en = 1'b1;
                if (acc_decided) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // tree_feat stays put from capture to the next capture so tree_hit is stable per select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_feat <= '0;
            tree_sel  <= '0;
            out_votes <= '0;
            out_class <= 1'b0;
        end else if (accept) begin
            tree_feat <= in_feat;
            tree_sel  <= '0;
        end else if (eval_en) begin
            if (acc_decided) begin
                out_votes <= acc_count;
                out_class <= acc_class;
            end else begin
                tree_sel <= tree_sel + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tree_ensemble_sched.sv
// Directed bench for tree_ensemble_sched (NUM_TREES=8, VOTE_THRESH=5); TREE_EARLY_EXIT_EN selects the early-stop vectors.
module tb_tree_ensemble_sched;

    localparam int FEAT_W = 51;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [FEAT_W-1:0] in_feat;
    logic [FEAT_W-1:0] tree_feat;
    logic [2:0]        tree_sel;
    logic              tree_hit;
    logic              out_valid;
    logic              out_ready;
    logic              out_class;
    logic [3:0]        out_votes;
    logic [7:0]        hit_mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Each tree's vote is a fixed per-index bit for the duration of a test.
    assign tree_hit = hit_mask[tree_sel];

    tree_ensemble_sched #(
        .FEAT_W     (FEAT_W),
        .NUM_TREES  (8),
        .VOTE_THRESH(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_feat  (in_feat),
        .tree_feat(tree_feat),
        .tree_sel (tree_sel),
        .tree_hit (tree_hit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_votes(out_votes)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " out_class"}, 64'(out_class), 64'd0);
        check({tag, " out_votes"}, 64'(out_votes), 64'd0);
        check({tag, " tree_sel"}, 64'(tree_sel), 64'd0);
        check({tag, " tree_feat"}, 64'(tree_feat), 64'd0);
    endtask

    logic [FEAT_W-1:0] feat_a;
    logic [FEAT_W-1:0] feat_b;
    bit                seen_valid;
    bit                got_ready;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_feat   = '0;
        out_ready = 1'b0;
        hit_mask  = 8'h00;
        feat_a    = 51'h5_5555_0F0F_1234;
        feat_b    = 51'h2_AAAA_F0F0_4321;

        // Reset state, then idle after release.
        #12;
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        tick();
        check_reset_vals("idle");

`ifndef TREE_EARLY_EXIT_EN
        // Five leading hits: full sweep, majority reached exactly at threshold.
        hit_mask = 8'b0001_1111;
        in_feat  = 51'h1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_feat  = '0;
        check("t2 in_ready_eval", 64'(in_ready), 64'd0);
        check("t2 tree_feat", 64'(tree_feat), 64'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2 sel%0d", i), 64'(tree_sel), 64'(i));
            check($sformatf("t2 novalid%0d", i), 64'(out_valid), 64'd0);
            tick();
        end
        check("t2 out_valid", 64'(out_valid), 64'd1);
        check("t2 out_votes", 64'(out_votes), 64'd5);
        check("t2 out_class", 64'(out_class), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2 valid_drop", 64'(out_valid), 64'd0);
        check("t2 in_ready_back", 64'(in_ready), 64'd1);

        // Single hit on the last tree, result held under backpressure.
        hit_mask = 8'h80;
        in_feat  = feat_a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t3 out_valid", 64'(out_valid), 64'd1);
        check("t3 out_votes", 64'(out_votes), 64'd1);
        check("t3 out_class", 64'(out_class), 64'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_feat  = feat_b;
            hit_mask = 8'hFF;
            tick();
            check($sformatf("t3 hold_valid%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("t3 hold_votes%0d", i), 64'(out_votes), 64'd1);
            check($sformatf("t3 hold_class%0d", i), 64'(out_class), 64'd0);
            check($sformatf("t3 hold_ready%0d", i), 64'(in_ready), 64'd0);
            check($sformatf("t3 hold_feat%0d", i), 64'(tree_feat), 64'(feat_a));
            check($sformatf("t3 hold_sel%0d", i), 64'(tree_sel), 64'd7);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3 released", 64'(out_valid), 64'd0);
        check("t3 feat_kept", 64'(tree_feat), 64'(feat_a));

        // Back-to-back: in_valid held, second accept exactly 10 cycles later.
        hit_mask  = 8'hFF;
        in_feat   = feat_b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_feat = feat_a;
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("t4 feat_first%0d", k), 64'(tree_feat), 64'(feat_b));
            check($sformatf("t4 in_ready%0d", k), 64'(in_ready), (k == 10) ? 64'd1 : 64'd0);
            check($sformatf("t4 out_valid%0d", k), 64'(out_valid), (k == 9) ? 64'd1 : 64'd0);
            if (k == 9) check("t4 votes_first", 64'(out_votes), 64'd8);
            tick();
        end
        in_valid = 1'b0;
        check("t4 feat_second", 64'(tree_feat), 64'(feat_a));
        check("t4 busy_second", 64'(in_ready), 64'd0);
        got_ready = 1'b0;
        for (int k = 0; k < 20 && !got_ready; k++) begin
            tick();
            got_ready = in_ready;
        end
        check("t4 second_done", 64'(got_ready), 64'd1);
        check("t4 votes_second", 64'(out_votes), 64'd8);
        check("t4 class_second", 64'(out_class), 64'd1);
        out_ready = 1'b0;
`else
        // Constant hits: class 1 decided on tree 4.
        hit_mask = 8'hFF;
        in_feat  = feat_a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("e1 sel%0d", i), 64'(tree_sel), 64'(i));
            check($sformatf("e1 novalid%0d", i), 64'(out_valid), 64'd0);
            tick();
        end
        check("e1 out_valid", 64'(out_valid), 64'd1);
        check("e1 out_votes", 64'(out_votes), 64'd5);
        check("e1 out_class", 64'(out_class), 64'd1);
        check("e1 sel_held", 64'(tree_sel), 64'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("e1 valid_drop", 64'(out_valid), 64'd0);

        // No hits: class 0 decided on tree 3.
        hit_mask = 8'h00;
        in_feat  = feat_b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("e0 sel%0d", i), 64'(tree_sel), 64'(i));
            check($sformatf("e0 novalid%0d", i), 64'(out_valid), 64'd0);
            tick();
        end
        check("e0 out_valid", 64'(out_valid), 64'd1);
        check("e0 out_votes", 64'(out_votes), 64'd0);
        check("e0 out_class", 64'(out_class), 64'd0);
        check("e0 sel_held", 64'(tree_sel), 64'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        // Reset mid-evaluation at tree 3 aborts with no result.
        hit_mask = 8'hFF;
        in_feat  = feat_b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("t5 sel_before", 64'(tree_sel), 64'd3);
        check("t5 busy_before", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t5 async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check("t5 no_valid", 64'(seen_valid), 64'd0);
        check("t5 idle_ready", 64'(in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
